// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter: default width, operation
// codes and the binary/Gray conversion helpers.
package gray_pkg;

  localparam int GRAY_WIDTH_DEFAULT = 3;
  localparam int GRAY_WIDTH_MAX     = 16;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_STEP  = 2'd1,
    OP_LOAD  = 2'd2,
    OP_CLEAR = 2'd3
  } gray_op_e;

  function automatic logic [GRAY_WIDTH_MAX-1:0] bin2gray(
    input logic [GRAY_WIDTH_MAX-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [GRAY_WIDTH_MAX-1:0] gray2bin(
    input logic [GRAY_WIDTH_MAX-1:0] g
  );
    logic [GRAY_WIDTH_MAX-1:0] b;
    b[GRAY_WIDTH_MAX-1] = g[GRAY_WIDTH_MAX-1];
    for (int i = GRAY_WIDTH_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_next.sv
// Combinational next-state logic: resolves clear/load/step priority and
// produces the next binary count, its Gray code and the wrap condition.
module gray_next
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] b,
  input  logic             dir,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             cen,
  output logic [WIDTH-1:0] bin_d,
  output logic [WIDTH-1:0] gray_d,
  output logic             wrap_d
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX = '1;

  gray_op_e op;

  always_comb begin
    op = OP_HOLD;
    if (clr) begin
      op = OP_CLEAR;
    end else if (ld) begin
      op = OP_LOAD;
    end else if (cen) begin
      op = OP_STEP;
    end
  end

  // Only a counting step may flag a wrap; clear and load never do.
  always_comb begin
    bin_d  = b;
    wrap_d = 1'b0;
    case (op)
      OP_CLEAR: bin_d = '0;
      OP_LOAD:  bin_d = ld_val;
      OP_STEP: begin
        if (dir) begin
          bin_d  = b + ONE;
          wrap_d = (b == MAX);
        end else begin
          bin_d  = b - ONE;
          wrap_d = (b == '0);
        end
      end
      default: bin_d = b;
    endcase
  end

  always_comb begin
    gray_d = bin_d ^ (bin_d >> 1);
  end

endmodule

// File: rtl/gray_counter.sv
// Parameterised Gray-code counter with clear, load, up/down and wrap pulse;
// all outputs come straight from registers loaded with next-state values.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             dir,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             wrap
);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] gray_d;
  logic             wrap_q;
  logic             wrap_d;

  gray_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .b      (bin_q),
    .dir    (dir),
    .clr    (clr),
    .ld     (ld),
    .ld_val (ld_val),
    .cen    (cen),
    .bin_d  (bin_d),
    .gray_d (gray_d),
    .wrap_d (wrap_d)
  );

  // Gray is registered alongside bin so neither output has decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed and randomised checks of gray_counter at WIDTH=3 and WIDTH=4.
module tb_gray_counter;
  import gray_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       cen;
  logic       dir;
  logic       clr;
  logic       ld;
  logic [2:0] ld_val3;
  logic [3:0] ld_val4;
  logic [2:0] gray3;
  logic [2:0] bin3;
  logic       wrap3;
  logic [3:0] gray4;
  logic [3:0] bin4;
  logic       wrap4;

  int vectors;
  int miscompares;

  gray_counter #(.WIDTH(3)) dut3 (
    .clk    (clk),
    .rst_n  (rst_n),
    .cen    (cen),
    .dir    (dir),
    .clr    (clr),
    .ld     (ld),
    .ld_val (ld_val3),
    .gray   (gray3),
    .bin    (bin3),
    .wrap   (wrap3)
  );

  gray_counter #(.WIDTH(4)) dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .cen    (cen),
    .dir    (dir),
    .clr    (clr),
    .ld     (ld),
    .ld_val (ld_val4),
    .gray   (gray4),
    .bin    (bin4),
    .wrap   (wrap4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkState3(input string tag, input logic [2:0] eb, input logic [2:0] eg,
                             input logic ew);
    checkOutput({tag, "/bin"},  16'(bin3),  16'(eb));
    checkOutput({tag, "/gray"}, 16'(gray3), 16'(eg));
    checkOutput({tag, "/wrap"}, 16'(wrap3), 16'(ew));
  endtask

  // Drive controls away from the edge, then sample 1 time unit after it.
  task automatic applyStimulus(input logic c, input logic d, input logic cl, input logic l,
                               input logic [3:0] v);
    cen     = c;
    dir     = d;
    clr     = cl;
    ld      = l;
    ld_val3 = v[2:0];
    ld_val4 = v;
    @(posedge clk);
    #1;
  endtask

  logic [2:0] up_gray [10] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111,
                               3'b101, 3'b100, 3'b000, 3'b001, 3'b011};
  logic [2:0] up_bin  [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
                               3'd6, 3'd7, 3'd0, 3'd1, 3'd2};

  initial begin
    logic [3:0] mb;
    logic [3:0] mb_next;
    logic       mwrap;
    logic       step;
    logic [3:0] prev_gray;
    logic       rc, rd, rcl, rl;
    logic [3:0] rv;

    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b1;
    cen = 1'b0; dir = 1'b0; clr = 1'b0; ld = 1'b0; ld_val3 = '0; ld_val4 = '0;

    #2 rst_n = 1'b0;
    #1 checkState3("reset_async", 3'd0, 3'd0, 1'b0);
    @(posedge clk); #1;
    checkState3("reset_hold", 3'd0, 3'd0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      checkState3($sformatf("idle%0d", i), 3'd0, 3'd0, 1'b0);
    end

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      checkState3($sformatf("up%0d", i), up_bin[i], up_gray[i], (i == 7));
    end

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    checkState3("clr", 3'd0, 3'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    checkState3("down_wrap", 3'd7, 3'b100, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    checkState3("down_next", 3'd6, 3'b101, 1'b0);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd5);
    checkState3("load5", 3'd5, 3'b111, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    checkState3("load5_step", 3'd6, 3'b101, 1'b0);

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd7);
    checkState3("clr_over_ld", 3'd0, 3'd0, 1'b0);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd7);
    checkState3("load_max", 3'd7, 3'b100, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    checkState3("max_up_wrap", 3'd0, 3'd0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    checkState3("hold", 3'd0, 3'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    checkState3("load_zero", 3'd0, 3'd0, 1'b0);

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    checkState3("pre_reset", 3'd3, 3'b010, 1'b0);
    #2 rst_n = 1'b0;
    #1 checkState3("mid_reset", 3'd0, 3'd0, 1'b0);
    @(posedge clk); #1;
    checkState3("mid_reset_hold", 3'd0, 3'd0, 1'b0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    checkState3("resume", 3'd1, 3'b001, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    checkState3("dir_flip", 3'd0, 3'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    checkState3("dir_flip_wrap", 3'd7, 3'b100, 1'b1);

    // Randomised phase against a behavioural model of the WIDTH=4 instance.
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    mb = 4'd0;
    checkOutput("rnd_reset", 16'(bin4), 16'd0);
    for (int i = 0; i < 1000; i++) begin
      rc  = 1'($urandom_range(0, 3) != 0);
      rd  = 1'($urandom);
      rcl = 1'($urandom_range(0, 15) == 0);
      rl  = 1'($urandom_range(0, 15) == 0);
      rv  = 4'($urandom);
      step  = 1'b0;
      mwrap = 1'b0;
      if (rcl) begin
        mb_next = 4'd0;
      end else if (rl) begin
        mb_next = rv;
      end else if (rc) begin
        step    = 1'b1;
        mb_next = rd ? mb + 4'd1 : mb - 4'd1;
        mwrap   = rd ? (mb == 4'hF) : (mb == 4'h0);
      end else begin
        mb_next = mb;
      end
      prev_gray = mb ^ (mb >> 1);
      applyStimulus(rc, rd, rcl, rl, rv);
      mb = mb_next;
      checkOutput($sformatf("rnd%0d/bin", i), 16'(bin4), 16'(mb));
      checkOutput($sformatf("rnd%0d/wrap", i), 16'(wrap4), 16'(mwrap));
      checkOutput($sformatf("rnd%0d/g2b", i), gray2bin(16'(gray4)), 16'(mb));
      if (step) begin
        checkOutput($sformatf("rnd%0d/onebit", i), 16'($countones(prev_gray ^ gray4)), 16'd1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
